fifo_ctrl: RTL

Pointer and flag controller that drives a dual-port RAM (write port plus asynchronous read port) to form a single-clock, show-ahead FIFO. It owns the write/read pointers, generates the RAM write enable and addresses, and produces occupancy flags and error pulses. The datapath (data in, q out) passes straight between the FIFO user and the RAM. This block carries only control.

---
 rtl/fifo_ctrl.sv | 82 ++++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a single-clock show-ahead FIFO built around a
// dual-port RAM with an asynchronous read port; carries control only, no data.
module fifo_ctrl #(
    parameter int AWIDTH       = 4,
    parameter int ALMOST_FULL  = 12,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic              ram_wren_o,
    output logic [AWIDTH-1:0] ram_wrpntr_o,
    output logic [AWIDTH-1:0] ram_rdpntr_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              ovf_o,
    output logic              udf_o
);

    localparam logic [AWIDTH:0] DEPTH  = (AWIDTH+1)'(2**AWIDTH);
    localparam logic [AWIDTH:0] AF_LVL = (AWIDTH+1)'(ALMOST_FULL);
    localparam logic [AWIDTH:0] AE_LVL = (AWIDTH+1)'(ALMOST_EMPTY);

    logic [AWIDTH:0] wrPtr_q, wrPtr_d;
    logic [AWIDTH:0] rdPtr_q, rdPtr_d;
    logic [AWIDTH:0] usedw_q, usedw_d;
    logic            empty_q, full_q;
    logic            almostFull_q, almostEmpty_q;
    logic            ovf_q, udf_q;
    logic            wrAcc, rdAcc;

    // Acceptance looks only at the registered flags, so a full FIFO never
    // writes through and an empty one never reads through.
    always_comb begin
        wrAcc   = wrreq_i & ~full_q;
        rdAcc   = rdreq_i & ~empty_q;
        wrPtr_d = wrPtr_q + {{AWIDTH{1'b0}}, wrAcc};
        rdPtr_d = rdPtr_q + {{AWIDTH{1'b0}}, rdAcc};
        usedw_d = wrPtr_d - rdPtr_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            usedw_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            almostFull_q  <= 1'b0;
            almostEmpty_q <= 1'b1;
            ovf_q         <= 1'b0;
            udf_q         <= 1'b0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            usedw_q       <= usedw_d;
            empty_q       <= (usedw_d == '0);
            full_q        <= (usedw_d == DEPTH);
            almostFull_q  <= (usedw_d >= AF_LVL);
            almostEmpty_q <= (usedw_d <= AE_LVL);
            ovf_q         <= wrreq_i & full_q;
            udf_q         <= rdreq_i & empty_q;
        end
    end

    // Gate with reset so the RAM cannot be written while the pointers are held.
    assign ram_wren_o     = wrAcc & rst_n_i;
    assign ram_wrpntr_o   = wrPtr_q[AWIDTH-1:0];
    assign ram_rdpntr_o   = rdPtr_q[AWIDTH-1:0];
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign usedw_o        = usedw_q;
    assign almost_full_o  = almostFull_q;
    assign almost_empty_o = almostEmpty_q;
    assign ovf_o          = ovf_q;
    assign udf_o          = udf_q;

endmodule
